// File: rtl/bf_exec_unit.sv
// Brainf*ck execution core: fetches 3-bit opcodes from a program ROM, operates on a
// registered-read data RAM, and exchanges bytes over valid/ready style handshakes.
module bf_exec_unit #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned DADDR_W     = 8,
  parameter int unsigned PADDR_W     = 10,
  parameter int unsigned STACK_DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               run,
  output logic [PADDR_W-1:0] prog_addr,
  input  logic [2:0]         prog_code,
  input  logic               prog_end,
  output logic [DADDR_W-1:0] dmem_addr,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic [DATA_W-1:0]  dmem_wdata,
  output logic               dmem_we,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               busy,
  output logic               halted,
  output logic               error,
  output logic [1:0]         err_code
);

  localparam int unsigned SP_W    = $clog2(STACK_DEPTH + 1);
  localparam int unsigned SIDX_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int unsigned DEPTH_W = PADDR_W + 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC, S_SCAN, S_OUT, S_IN, S_HALT, S_ERROR
  } state_t;

  typedef enum logic [2:0] {
    OP_RIGHT, OP_LEFT, OP_INC, OP_DEC, OP_OUT, OP_IN, OP_OPEN, OP_CLOSE
  } op_t;

  state_t               state_q, state_d;
  op_t                  op_q, op_d;
  logic [PADDR_W-1:0]   pc_q, pc_d;
  logic [DADDR_W-1:0]   dptr_q, dptr_d;
  logic [SP_W-1:0]      sp_q, sp_d;
  logic [DEPTH_W-1:0]   depth_q, depth_d;
  logic [1:0]           err_q, err_d;
  logic [DATA_W-1:0]    out_q, out_d;
  logic                 push;
  logic [PADDR_W-1:0]   stack [STACK_DEPTH];
  logic [SP_W-1:0]      sp_top;
  logic                 cell_zero;
  op_t                  scan_op;

  assign sp_top    = sp_q - SP_W'(1);
  assign cell_zero = (dmem_rdata == '0);
  assign scan_op   = op_t'(prog_code);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_RIGHT;
      pc_q    <= '0;
      dptr_q  <= '0;
      sp_q    <= '0;
      depth_q <= '0;
      err_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      pc_q    <= pc_d;
      dptr_q  <= dptr_d;
      sp_q    <= sp_d;
      depth_q <= depth_d;
      err_q   <= err_d;
      out_q   <= out_d;
      if (push) stack[sp_q[SIDX_W-1:0]] <= pc_q;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    pc_d    = pc_q;
    dptr_d  = dptr_q;
    sp_d    = sp_q;
    depth_d = depth_q;
    err_d   = err_q;
    out_d   = out_q;
    push    = 1'b0;
    unique case (state_q)
      S_IDLE, S_HALT, S_ERROR: begin
        if (start) begin
          pc_d    = '0;
          dptr_d  = '0;
          sp_d    = '0;
          depth_d = '0;
          err_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (run) begin
          if (prog_end) begin
            state_d = S_HALT;
          end else begin
            op_d    = op_t'(prog_code);
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_q + PADDR_W'(1);
        unique case (op_q)
          OP_RIGHT: dptr_d = dptr_q + DADDR_W'(1);
          OP_LEFT:  dptr_d = dptr_q - DADDR_W'(1);
          OP_INC, OP_DEC: ;
          OP_OUT: begin
            out_d   = dmem_rdata;
            pc_d    = pc_q;
            state_d = S_OUT;
          end
          OP_IN: begin
            pc_d    = pc_q;
            state_d = S_IN;
          end
          OP_OPEN: begin
            if (cell_zero) begin
              depth_d = DEPTH_W'(1);
              state_d = S_SCAN;
            end else if (sp_q == SP_FULL) begin
              pc_d    = pc_q;
              err_d   = 2'd1;
              state_d = S_ERROR;
            end else begin
              push = 1'b1;
              sp_d = sp_q + SP_W'(1);
            end
          end
          OP_CLOSE: begin
            if (sp_q == '0) begin
              pc_d    = pc_q;
              err_d   = 2'd2;
              state_d = S_ERROR;
            end else if (!cell_zero) begin
              pc_d = stack[sp_top[SIDX_W-1:0]] + PADDR_W'(1);
            end else begin
              sp_d = sp_top;
            end
          end
        endcase
      end
      S_SCAN: begin
        if (prog_end) begin
          err_d   = 2'd3;
          state_d = S_ERROR;
        end else begin
          pc_d = pc_q + PADDR_W'(1);
          if (scan_op == OP_OPEN) depth_d = depth_q + DEPTH_W'(1);
          if (scan_op == OP_CLOSE) begin
            depth_d = depth_q - DEPTH_W'(1);
            if (depth_q == DEPTH_W'(1)) state_d = S_FETCH;
          end
        end
      end
      S_OUT: begin
        if (out_ready) begin
          pc_d    = pc_q + PADDR_W'(1);
          state_d = S_FETCH;
        end
      end
      S_IN: begin
        if (in_valid) begin
          pc_d    = pc_q + PADDR_W'(1);
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dmem_we    = 1'b0;
    dmem_wdata = '0;
    if (state_q == S_EXEC && op_q == OP_INC) begin
      dmem_we    = 1'b1;
      dmem_wdata = dmem_rdata + DATA_W'(1);
    end else if (state_q == S_EXEC && op_q == OP_DEC) begin
      dmem_we    = 1'b1;
      dmem_wdata = dmem_rdata - DATA_W'(1);
    end else if (state_q == S_IN && in_valid) begin
      dmem_we    = 1'b1;
      dmem_wdata = in_data;
    end
    out_valid = (state_q == S_OUT);
    in_ready  = (state_q == S_IN);
    halted    = (state_q == S_HALT);
    error     = (state_q == S_ERROR);
    busy      = !(state_q == S_IDLE || state_q == S_HALT || state_q == S_ERROR);
  end

  assign prog_addr = pc_q;
  assign dmem_addr = dptr_q;
  assign out_data  = out_q;
  assign err_code  = err_q;

endmodule

// File: tb/tb_bf_exec_unit.sv
// Directed bench for bf_exec_unit: behavioural ROM/RAM around the core, hand-derived
// expectations for cell values, pc traces, cycle counts and handshake behaviour.
module tb_bf_exec_unit;

  logic       clk = 1'b0;
  logic       rst, start, run;
  logic [9:0] prog_addr;
  logic [2:0] prog_code;
  logic       prog_end;
  logic [7:0] dmem_addr, dmem_rdata, dmem_wdata;
  logic       dmem_we;
  logic [7:0] out_data, in_data;
  logic       out_valid, out_ready, in_valid, in_ready;
  logic       busy, halted, error;
  logic [1:0] err_code;

  int n_cmp = 0;
  int n_err = 0;

  logic [2:0] prog [1024];
  int         prog_len = 0;
  logic [7:0] mem [256];
  logic       mem_clr = 1'b0;

  int         out_beats = 0;
  logic [7:0] last_out = '0;
  int         in_rdy_cnt = 0;
  logic [7:0] wr_addr_q [$];
  logic [7:0] wr_data_q [$];
  logic [9:0] pc_trace [$];
  logic [9:0] pc_prev = '0;

  always #5 clk = ~clk;

  bf_exec_unit #(.DATA_W(8), .DADDR_W(8), .PADDR_W(10), .STACK_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .run(run),
    .prog_addr(prog_addr), .prog_code(prog_code), .prog_end(prog_end),
    .dmem_addr(dmem_addr), .dmem_rdata(dmem_rdata), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .busy(busy), .halted(halted), .error(error), .err_code(err_code)
  );

  assign prog_code = prog[prog_addr];
  assign prog_end  = (32'(prog_addr) >= 32'(prog_len));

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (dmem_we) begin
      mem[dmem_addr] <= dmem_wdata;
    end
    dmem_rdata <= mem[dmem_addr];
  end

  always @(posedge clk) begin
    if (out_valid && out_ready) begin
      out_beats++;
      last_out = out_data;
    end
    if (in_ready) in_rdy_cnt++;
    if (dmem_we) begin
      wr_addr_q.push_back(dmem_addr);
      wr_data_q.push_back(dmem_wdata);
    end
  end

  always @(negedge clk) begin
    if (prog_addr != pc_prev) begin
      pc_trace.push_back(prog_addr);
      pc_prev = prog_addr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] enc(input byte c);
    case (c)
      ">": return 3'd0;
      "<": return 3'd1;
      "+": return 3'd2;
      "-": return 3'd3;
      ".": return 3'd4;
      ",": return 3'd5;
      "[": return 3'd6;
      default: return 3'd7;
    endcase
  endfunction

  task automatic load(input string s);
    prog_len = s.len();
    for (int i = 0; i < s.len(); i++) prog[i] = enc(s[i]);
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_clr = 1'b1; start = 1'b0; run = 1'b1;
    out_ready = 1'b1; in_valid = 1'b0; in_data = '0;
    tick(); tick();
    rst = 1'b0; mem_clr = 1'b0;
    wr_addr_q.delete(); wr_data_q.delete(); pc_trace.delete();
    out_beats = 0; in_rdy_cnt = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_end(input string tag, input int max, output int cyc);
    cyc = 0;
    while (!(halted || error) && cyc < max) begin
      tick();
      cyc++;
    end
    chk({tag, "_finished"}, 32'(halted | error), 1);
  endtask

  initial begin
    int cyc;
    string s;
    logic [9:0] exp_trace [8];

    for (int i = 0; i < 1024; i++) prog[i] = '0;
    do_reset();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_pc", 32'(prog_addr), 0);
    chk("rst_dptr", 32'(dmem_addr), 0);
    chk("rst_strobes", 32'({dmem_we, out_valid, in_ready}), 0);
    chk("rst_errcode", 32'(err_code), 0);

    // "+++." : one output beat of 3, ten cycles from FETCH to HALT
    load("+++.");
    pulse_start();
    chk("p1_busy", 32'(busy), 1);
    run_to_end("p1", 100, cyc);
    chk("p1_cycles", 32'(cyc), 10);
    chk("p1_beats", 32'(out_beats), 1);
    chk("p1_outdata", 32'(last_out), 3);
    chk("p1_halted", 32'(halted), 1);
    chk("p1_pc", 32'(prog_addr), 4);
    chk("p1_cell0", 32'(mem[0]), 3);

    // pointer wrap both ways
    do_reset();
    load("<+");
    pulse_start();
    run_to_end("p2a", 100, cyc);
    chk("p2a_cycles", 32'(cyc), 5);
    chk("p2a_dptr", 32'(dmem_addr), 255);
    chk("p2a_cell255", 32'(mem[255]), 1);
    do_reset();
    load("<+>");
    pulse_start();
    run_to_end("p2b", 100, cyc);
    chk("p2b_dptr", 32'(dmem_addr), 0);
    chk("p2b_nwr", 32'(wr_addr_q.size()), 1);
    chk("p2b_waddr", 32'(wr_addr_q[0]), 255);
    chk("p2b_wdata", 32'(wr_data_q[0]), 1);

    // '-' wraps cell value
    do_reset();
    load("-");
    pulse_start();
    run_to_end("p2c", 100, cyc);
    chk("p2c_cell0", 32'(mem[0]), 255);

    // "++[-]" : loop body runs twice, one backward jump
    do_reset();
    load("++[-]");
    pulse_start();
    run_to_end("p3", 200, cyc);
    chk("p3_cycles", 32'(cyc), 15);
    chk("p3_nwr", 32'(wr_data_q.size()), 4);
    chk("p3_w0", 32'(wr_data_q[0]), 1);
    chk("p3_w1", 32'(wr_data_q[1]), 2);
    chk("p3_w2", 32'(wr_data_q[2]), 1);
    chk("p3_w3", 32'(wr_data_q[3]), 0);
    exp_trace = '{10'd1, 10'd2, 10'd3, 10'd4, 10'd3, 10'd4, 10'd5, 10'd0};
    chk("p3_ntrace", 32'(pc_trace.size()), 7);
    for (int i = 0; i < 7; i++) chk($sformatf("p3_trace%0d", i), 32'(pc_trace[i]), 32'(exp_trace[i]));
    chk("p3_sp", 32'(dut.sp_q), 0);
    chk("p3_halted", 32'(halted), 1);

    // "[[+]]+" with cell0=0 : nested skip lands on pc 5
    do_reset();
    load("[[+]]+");
    pulse_start();
    run_to_end("p4", 200, cyc);
    chk("p4_cycles", 32'(cyc), 9);
    chk("p4_cell0", 32'(mem[0]), 1);
    chk("p4_nwr", 32'(wr_data_q.size()), 1);
    chk("p4_pc", 32'(prog_addr), 6);
    chk("p4_ntrace", 32'(pc_trace.size()), 6);

    // stack overflow on the 17th nested '['
    do_reset();
    s = "+";
    for (int i = 0; i < 17; i++) s = {s, "["};
    load(s);
    pulse_start();
    run_to_end("p5", 200, cyc);
    chk("p5_error", 32'(error), 1);
    chk("p5_errcode", 32'(err_code), 1);
    chk("p5_pc", 32'(prog_addr), 17);
    chk("p5_busy", 32'({busy, halted}), 0);

    // unmatched brackets
    do_reset();
    load("+]");
    pulse_start();
    run_to_end("p6a", 100, cyc);
    chk("p6a_errcode", 32'(err_code), 2);
    chk("p6a_pc", 32'(prog_addr), 1);
    do_reset();
    load("[");
    pulse_start();
    run_to_end("p6b", 100, cyc);
    chk("p6b_errcode", 32'(err_code), 3);
    chk("p6b_error", 32'(error), 1);
    // restart from ERROR clears err_code
    load("+");
    pulse_start();
    chk("p6c_errcode", 32'(err_code), 0);
    run_to_end("p6c", 100, cyc);
    chk("p6c_halted", 32'(halted), 1);

    // run low holds in FETCH
    do_reset();
    load("+");
    run = 1'b0;
    pulse_start();
    for (int i = 0; i < 5; i++) tick();
    chk("p7_hold_pc", 32'(prog_addr), 0);
    chk("p7_hold_nwr", 32'(wr_data_q.size()), 0);
    chk("p7_hold_busy", 32'(busy), 1);
    run = 1'b1;
    run_to_end("p7", 100, cyc);
    chk("p7_cell0", 32'(mem[0]), 1);

    // ',' with input stalled five cycles
    do_reset();
    load(",");
    pulse_start();
    tick(); tick();
    chk("p8_inready", 32'(in_ready), 1);
    for (int i = 0; i < 5; i++) tick();
    chk("p8_stall_nwr", 32'(wr_data_q.size()), 0);
    in_valid = 1'b1; in_data = 8'h41;
    tick();
    in_valid = 1'b0; in_data = 8'h00;
    run_to_end("p8", 100, cyc);
    chk("p8_rdycnt", 32'(in_rdy_cnt), 6);
    chk("p8_nwr", 32'(wr_data_q.size()), 1);
    chk("p8_wdata", 32'(wr_data_q[0]), 32'h41);
    chk("p8_cell0", 32'(mem[0]), 32'h41);

    // stalled OUT holds data, then reset aborts it
    do_reset();
    load("+.");
    out_ready = 1'b0;
    pulse_start();
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("p9_valid", 32'(out_valid), 1);
    chk("p9_wait", 32'(cyc), 4);
    for (int i = 0; i < 3; i++) tick();
    chk("p9_stall_valid", 32'(out_valid), 1);
    chk("p9_stall_data", 32'(out_data), 1);
    chk("p9_stall_pc", 32'(prog_addr), 1);
    rst = 1'b1;
    tick();
    chk("p9_rst_valid", 32'(out_valid), 0);
    chk("p9_rst_busy", 32'(busy), 0);
    chk("p9_rst_pc", 32'(prog_addr), 0);
    chk("p9_beats", 32'(out_beats), 0);
    // reset beats a simultaneous start
    start = 1'b1;
    tick();
    chk("p9_rst_prio", 32'(busy), 0);
    start = 1'b0; rst = 1'b0;
    tick();
    chk("p9_idle", 32'({busy, halted, error}), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bf_exec_unit.md
BF_EXEC_UNIT -- requirements
Module: bf_exec_unit

Interface
REQ-001 SHALL have parameters (name, default, meaning): DATA_W, 8, data cell width; DADDR_W, 8, data pointer width; PADDR_W, 10, program address width; STACK_DEPTH, 16, loop-return stack entries.
REQ-002 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock.
- rst  in  1  reset; synchronous and active-high.
- start  in  1  pulse; begins execution from IDLE, HALT or ERROR.
- run  in  1  level; when low, the FSM holds in FETCH.
- prog_addr  out  PADDR_W  program counter to ROM.
- prog_code  in  3  opcode, combinational from prog_addr.
- prog_end  in  1  ROM overrun flag for prog_addr.
- dmem_addr  out  DADDR_W  data pointer to RAM.
- dmem_rdata  in  DATA_W  RAM read data; registered, 1-cycle latency.
- dmem_wdata  out  DATA_W  RAM write data.
- dmem_we  out  1  RAM write strobe.
- out_data  out  DATA_W  '.' output byte.
- out_valid  out  1  output handshake valid.
- out_ready  in  1  output handshake ready.
- in_data  in  DATA_W  ',' input byte.
- in_valid  in  1  input handshake valid.
- in_ready  out  1  input handshake ready.
- busy  out  1  state is not IDLE, HALT or ERROR.
- halted  out  1  state is HALT.
- error  out  1  state is ERROR.
- err_code  out  2  1=stack overflow, 2=unmatched ']', 3=unmatched '['.

Function
REQ-003 SHALL use this opcode map: 0 '>', 1 '<', 2 '+', 3 '-', 4 '.', 5 ',', 6 '[', 7 ']'.
REQ-004 SHALL implement FSM states IDLE, FETCH, EXEC, SCAN, OUT, IN, HALT, ERROR.
REQ-005 start in IDLE/HALT/ERROR SHALL clear pc, dptr, sp, scan depth and err_code, then enter FETCH; RAM contents SHALL NOT be cleared; start SHALL be ignored in other states.
REQ-006 FETCH SHALL:
- hold while run=0;
- go to HALT if prog_end=1;
- otherwise latch prog_code and go to EXEC.
REQ-006a dmem_addr SHALL equal dptr at all times.
REQ-007 In EXEC, dmem_rdata SHALL be treated as cell[dptr].
REQ-008 '>'/'<' SHALL increment/decrement dptr modulo 2^DADDR_W (255+1=0, 0-1=255 at default), then pc+1, FETCH.
REQ-009 '+'/'-' SHALL assert dmem_we for the EXEC cycle only, with dmem_wdata = rdata±1 modulo 2^DATA_W, then pc+1, FETCH.
REQ-010 '.' SHALL go to OUT.
- out_data = rdata, held stable; out_valid=1 throughout OUT.
- On out_valid&&out_ready: pc+1, FETCH.
REQ-011 ',' SHALL go to IN.
- in_ready=1 throughout IN.
- On in_valid: dmem_we=1 and dmem_wdata=in_data for exactly that cycle, then pc+1, FETCH.
REQ-012 '[' with rdata≠0 SHALL push pc and then pc+1.
- If sp==STACK_DEPTH: ERROR, err_code=1, no push.
REQ-013 '[' with rdata==0 SHALL set scan depth=1, pc+1, and go to SCAN.
REQ-014 SCAN SHALL evaluate one prog_code per cycle.
- '[': depth+1. ']': depth-1. Other opcodes: no change.
- If depth reaches 0: pc+1, FETCH. Otherwise pc+1, stay in SCAN.
- prog_end in SCAN: ERROR, err_code=3.
- Depth counter SHALL be PADDR_W+1 bits and SHALL NOT use the stack.
REQ-015 ']' with sp==0 SHALL go to ERROR, err_code=2.
- rdata≠0: pc = stack top + 1, no pop.
- rdata==0: pop, pc+1.
REQ-016 pc SHALL NOT wrap; an overrun is reported only through prog_end.
REQ-017 Instruction latency (FETCH to next FETCH) SHALL be 2 cycles for all opcodes except '.', ',', and zero-'['.
- '.' and ',': 2 cycles plus handshake wait cycles.
- Zero-'[': 2 cycles plus 1 per SCAN cycle.
REQ-018 Handshake data out_data SHALL NOT change while out_valid=1 and out_ready=0.
REQ-019 HALT and ERROR SHALL hold pc and dptr, and assert no strobes.

Reset
REQ-020 On rst=1 at a clk edge, all of the following SHALL hold, overriding any in-progress state including an OUT/IN handshake:
- state=IDLE;
- pc, dptr, sp, scan depth and err_code = 0;
- dmem_we, out_valid, in_ready, busy, halted and error = 0.
REQ-021 rst SHALL take priority over start.

Verification
REQ-022 Program "+++." (codes 2,2,2,4) then prog_end, cell0=0, out_ready=1 -> one out_valid beat with out_data=3, then halted=1, pc=4.
REQ-023 Program "<+" from reset -> dptr=255 and cell255=1 written; a following '>' -> dptr=0.
REQ-024 Program "++[-]" -> cell0 counts 2,1,0; ']' jumps to pc=3 once, then pops; sp=0 and halted=1 at the end.
REQ-025 cell0=0, "[[+]]+" -> SCAN skips to pc=5; final cell0=1.
REQ-026 Program with 17 nested '[' with cell≠0 (STACK_DEPTH=16) -> error=1, err_code=1, pc at the 17th '['.
REQ-027 ',' with in_valid held low for 5 cycles then in_valid=1, in_data=0x41 -> in_ready high for 6 cycles, single dmem_we with 0x41; rst asserted during a stalled OUT -> out_valid=0 on the next cycle.
